// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt priority controller.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      BUSY  = 2'd2
   } irq_state_t;

   localparam int IRQ_N_DEFAULT = 4;

endpackage

// File: rtl/priority_onehot.sv
// Combinational fixed-priority picker: highest set index wins, output is one-hot
// (all zero when no input bit is set).
module priority_onehot #(
   parameter int N = 4
) (
   input  logic [N-1:0] in_vec,
   output logic [N-1:0] onehot
);

   assign onehot[N-1] = in_vec[N-1];

   genvar gi;
   generate
      for (gi = 0; gi < N - 1; gi++) begin : g_bit
         // A bit wins only if nothing above it is requesting.
         assign onehot[gi] = in_vec[gi] & ~(|in_vec[N-1:gi+1]);
      end
   endgenerate

endmodule

// File: rtl/irq_priority_ctrl.sv
// Interrupt priority controller: captures requests into a pending vector, offers the
// highest-priority unmasked line, then waits for service. Define IRQ_EDGE_DETECT_EN for
// rising-edge capture; otherwise requests are level-captured.
module irq_priority_ctrl
   import irq_pkg::*;
#(
   parameter int N   = IRQ_N_DEFAULT,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   mask,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_grant,
   output logic [IDW-1:0] out_id,
   input  logic           svc_done,
   output logic [N-1:0]   pending
);

   irq_state_t     state_reg, state_next;
   logic [N-1:0]   pending_reg, pending_next;
   logic [N-1:0]   grant_reg, grant_next;
   logic [IDW-1:0] id_reg, id_next;
   logic [N-1:0]   set_vec;
   logic [N-1:0]   clr_vec;
   logic [N-1:0]   eligible;
   logic [N-1:0]   sel;
   logic [IDW-1:0] sel_id;
   logic           handshake;

`ifdef IRQ_EDGE_DETECT_EN
   logic [N-1:0] hist_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_reg <= '0;
      end else begin
         hist_reg <= req;
      end
   end

   assign set_vec = req & ~hist_reg;
`else
   assign set_vec = req;
`endif

   assign handshake = (state_reg == OFFER) && out_ready;
   assign clr_vec   = handshake ? grant_reg : '0;
   // Set is applied after clear so a coincident new request is not lost.
   assign pending_next = (pending_reg & ~clr_vec) | set_vec;
   assign eligible     = pending_reg & ~mask;

   priority_onehot #(.N(N)) u_prio (
      .in_vec (eligible),
      .onehot (sel)
   );

   always_comb begin
      sel_id = '0;
      for (int i = 0; i < N; i++) begin
         if (sel[i]) begin
            sel_id = IDW'(i);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      id_next    = id_reg;
      case (state_reg)
         IDLE: begin
            if (|sel) begin
               state_next = OFFER;
               grant_next = sel;
               id_next    = sel_id;
            end
         end
         OFFER: begin
            // Grant is frozen here; mask/pending changes cannot withdraw it.
            if (out_ready) begin
               state_next = BUSY;
               grant_next = '0;
               id_next    = '0;
            end
         end
         BUSY: begin
            if (svc_done) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
            id_next    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         pending_reg <= '0;
         grant_reg   <= '0;
         id_reg      <= '0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         grant_reg   <= grant_next;
         id_reg      <= id_next;
      end
   end

   assign out_valid = (state_reg == OFFER);
   assign out_grant = grant_reg;
   assign out_id    = id_reg;
   assign pending   = pending_reg;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Self-checking bench for irq_priority_ctrl (N=4); expected grants are queued when
// requests are driven and compared when the controller offers them.
module tb_irq_priority_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] mask;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_grant;
   logic [1:0] out_id;
   logic       svc_done;
   logic [3:0] pending;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] id;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run = 0;
   int   fails     = 0;

   irq_priority_ctrl #(.N(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mask      (mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_grant (out_grant),
      .out_id    (out_id),
      .svc_done  (svc_done),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_req(input logic [3:0] v);
      req = v;
      tick();
      req = '0;
   endtask

   task automatic push_exp(input logic [3:0] g, input logic [1:0] id);
      exp_t e;
      e.grant = g;
      e.id    = id;
      exp_q.push_back(e);
   endtask

   // Wait for an offer, compare it against the scoreboard, accept it and finish service.
   task automatic serve();
      exp_t e;
      int   n;
      n = 0;
      tests_run++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL serve_queue: scoreboard empty, required one entry");
         return;
      end
      e = exp_q.pop_front();
      while (out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      tests_run++;
      if (out_valid !== 1'b1) begin
         fails++;
         $display("FAIL serve_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
         return;
      end
      tests_run++;
      if (out_grant !== e.grant) begin
         fails++;
         $display("FAIL serve_grant: out_grant=%b required %b", out_grant, e.grant);
      end
      tests_run++;
      if (out_id !== e.id) begin
         fails++;
         $display("FAIL serve_id: out_id=%0d required %0d", out_id, e.id);
      end
      $display("[TB] offer grant=%b id=%0d", out_grant, out_id);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || out_grant !== 4'b0000 || out_id !== 2'd0) begin
         fails++;
         $display("FAIL serve_busy: valid=%b grant=%b id=%0d required 0/0000/0", out_valid, out_grant, out_id);
      end
      svc_done = 1'b1;
      tick();
      svc_done = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL serve_idle_gap: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0; req = '0; mask = '0; out_ready = 1'b0; svc_done = 1'b0;
      #12;
      tests_run++;
      if (out_valid !== 1'b0 || pending !== 4'b0000 || out_grant !== 4'b0000 || out_id !== 2'd0) begin
         fails++;
         $display("FAIL reset_state: valid=%b pending=%b grant=%b id=%0d required all 0", out_valid, pending, out_grant, out_id);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      pulse_req(4'b0010);
      n = 0;
      while (out_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      tests_run++;
      if (out_valid !== 1'b1) begin
         fails++;
         $display("FAIL reset_offer: out_valid=%b required 1 before reset", out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || pending !== 4'b0000 || out_grant !== 4'b0000 || out_id !== 2'd0) begin
         fails++;
         $display("FAIL reset_async: valid=%b pending=%b grant=%b id=%0d required all 0", out_valid, pending, out_grant, out_id);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b0 || pending !== 4'b0000) begin
            fails++;
            $display("FAIL reset_no_reissue: valid=%b pending=%b required 0/0000", out_valid, pending);
         end
      end
      $display("[TB] reset checks done");
   endtask

   task automatic test_priority();
      pulse_req(4'b0101);
      tests_run++;
      if (pending !== 4'b0101 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL prio_capture: pending=%b valid=%b required 0101/0", pending, out_valid);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1) begin
         fails++;
         $display("FAIL prio_latency: out_valid=%b required 1 one cycle after pending", out_valid);
      end
      push_exp(4'b0100, 2'd2);
      push_exp(4'b0001, 2'd0);
      serve();
      tests_run++;
      if (pending !== 4'b0001) begin
         fails++;
         $display("FAIL prio_pending_after_first: pending=%b required 0001", pending);
      end
      serve();
   endtask

   task automatic test_stall();
      int n;
      pulse_req(4'b0100);
      push_exp(4'b0100, 2'd2);
      push_exp(4'b1000, 2'd3);
      n = 0;
      while (out_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         tests_run++;
         if (out_valid !== 1'b1 || out_grant !== 4'b0100 || out_id !== 2'd2) begin
            fails++;
            $display("FAIL stall_hold: cycle %0d valid=%b grant=%b id=%0d required 1/0100/2", k, out_valid, out_grant, out_id);
         end
         req  = (k == 1) ? 4'b1000 : 4'b0000;
         mask = (k >= 2) ? 4'b0100 : 4'b0000;
         tick();
      end
      req  = '0;
      mask = '0;
      tests_run++;
      if (pending !== 4'b1100) begin
         fails++;
         $display("FAIL stall_pending: pending=%b required 1100", pending);
      end
      serve();
      serve();
   endtask

   task automatic test_mask();
      mask = 4'b1000;
      pulse_req(4'b1010);
      push_exp(4'b0010, 2'd1);
      serve();
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if (out_valid !== 1'b0 || pending !== 4'b1000) begin
            fails++;
            $display("FAIL mask_retain: valid=%b pending=%b required 0/1000", out_valid, pending);
         end
         tick();
      end
      mask = '0;
      push_exp(4'b1000, 2'd3);
      serve();
   endtask

   task automatic test_set_wins();
      int n;
      pulse_req(4'b0010);
      n = 0;
      while (out_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      tests_run++;
      if (out_valid !== 1'b1 || out_grant !== 4'b0010) begin
         fails++;
         $display("FAIL setwins_offer: valid=%b grant=%b required 1/0010", out_valid, out_grant);
      end
      req       = 4'b0010;
      out_ready = 1'b1;
      tick();
      req       = '0;
      out_ready = 1'b0;
      tests_run++;
      if (pending[1] !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL setwins_pending: pending=%b valid=%b required pending[1]=1 valid=0", pending, out_valid);
      end
      svc_done = 1'b1;
      tick();
      svc_done = 1'b0;
      push_exp(4'b0010, 2'd1);
      serve();
      tests_run++;
      if (pending !== 4'b0000) begin
         fails++;
         $display("FAIL setwins_drain: pending=%b required 0000", pending);
      end
   endtask

   task automatic test_capture_mode();
      int count;
      count     = 0;
      out_ready = 1'b1;
      svc_done  = 1'b1;
      req       = 4'b0001;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc == 10) req = '0;
         if (out_valid === 1'b1) begin
            count++;
            tests_run++;
            if (out_grant !== 4'b0001) begin
               fails++;
               $display("FAIL capture_grant: out_grant=%b required 0001", out_grant);
            end
         end
         tick();
      end
      out_ready = 1'b0;
      svc_done  = 1'b0;
      $display("[TB] capture mode grants=%0d", count);
      tests_run++;
`ifdef IRQ_EDGE_DETECT_EN
      if (count != 1) begin
         fails++;
         $display("FAIL capture_count: grants=%0d required 1 (edge mode)", count);
      end
`else
      if (count < 2) begin
         fails++;
         $display("FAIL capture_count: grants=%0d required >=2 (level mode)", count);
      end
`endif
      tests_run++;
      if (pending !== 4'b0000 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL capture_drain: pending=%b valid=%b required 0000/0", pending, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_stall();
      test_mask();
      test_set_wins();
      test_capture_mode();
      tests_run++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
